three_pulses_pwm_capture: RTL and testbench

- Receive-side monitor for the 2-bit three-pulse PWM drive code: 10 = positive pulse, 01 = negative pulse, 00 = no pulse.
- Synchronises the code and measures each half-cycle: pulse count, individual pulse widths and half-cycle period, all in clk100MHz cycles.
- Feeds the frequency-locking controller and on-board self-check, closing the loop on the generator's increment/modulation settings.

---
 rtl/three_pulses_pwm_capture.sv | 167 ++++++++++++++++
 tb/tb_three_pulses_pwm_capture.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/three_pulses_pwm_capture.sv
// Receive-side monitor for the 2-bit three-pulse PWM drive code: measures pulse count, widths and period
// of each half-cycle. Optional macro CAPTURE_FULL_PERIOD_EN adds meas_full_period (sum of the last two periods).
module three_pulses_pwm_capture #(
    parameter int CNT_W       = 16,
    parameter int MAX_PULSES  = 3,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 65535
) (
    input  logic                        clk100MHz,
    input  logic                        reset,
    input  logic [1:0]                  pwm_drive,
    output logic                        meas_valid,
    output logic                        meas_polarity,
    output logic [1:0]                  meas_count,
    output logic [MAX_PULSES*CNT_W-1:0] meas_widths,
    output logic [CNT_W-1:0]            meas_period,
    output logic                        code_error,
    output logic                        signal_lost,
`ifdef CAPTURE_FULL_PERIOD_EN
    output logic [CNT_W:0]              meas_full_period,
`endif
    output logic                        dbg_measuring
);

    localparam int PC_W   = $clog2(MAX_PULSES + 2);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [PC_W-1:0]   PC_SAT   = PC_W'(MAX_PULSES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LIM = IDLE_W'(TIMEOUT - 1);

    typedef enum logic {IDLE, MEASURE} state_t;

    state_t            state;
    logic [1:0]        sync_q [SYNC_STAGES];
    logic [1:0]        q, q_prev;
    logic              cur_pol;
    logic [CNT_W-1:0]  slots     [MAX_PULSES];
    logic [CNT_W-1:0]  slots_upd [MAX_PULSES];
    logic [CNT_W-1:0]  width_cnt, period_cnt;
    logic [PC_W-1:0]   pulse_cnt;
    logic [IDLE_W-1:0] idle_cnt;
`ifdef CAPTURE_FULL_PERIOD_EN
    logic [CNT_W-1:0]  last_period;
    logic              last_pol;
    logic              have_prev;
`endif

    logic pulse, prev_pulse, pol, pulse_start, pulse_end;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk100MHz or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 2'b00;
            q      <= 2'b00;
            q_prev <= 2'b00;
        end else begin
            sync_q[0] <= pwm_drive;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            q      <= sync_q[SYNC_STAGES-1];
            q_prev <= q;
        end
    end

    // Code 11 is not a pulse; a direct 10<->01 swap is an end and a start in the same cycle.
    assign pulse       = q[1] ^ q[0];
    assign prev_pulse  = q_prev[1] ^ q_prev[0];
    assign pol         = q[1];
    assign pulse_start = pulse & (~prev_pulse | (q != q_prev));
    assign pulse_end   = prev_pulse & (~pulse | (q != q_prev));

    always_comb begin
        for (int k = 0; k < MAX_PULSES; k++) begin
            slots_upd[k] = slots[k];
            if (pulse_end && pulse_cnt == PC_W'(k + 1)) slots_upd[k] = width_cnt;
        end
    end

    assign dbg_measuring = (state == MEASURE);

    // meas_valid is a one-cycle strobe with no back-pressure; all meas_* fields are stable from that cycle
    // until the next strobe.
    always_ff @(posedge clk100MHz or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cur_pol       <= 1'b0;
            slots         <= '{default: '0};
            width_cnt     <= '0;
            period_cnt    <= '0;
            pulse_cnt     <= '0;
            idle_cnt      <= '0;
            meas_valid    <= 1'b0;
            meas_polarity <= 1'b0;
            meas_count    <= 2'd0;
            meas_widths   <= '0;
            meas_period   <= '0;
            code_error    <= 1'b0;
            signal_lost   <= 1'b1;
`ifdef CAPTURE_FULL_PERIOD_EN
            meas_full_period <= '0;
            last_period      <= '0;
            last_pol         <= 1'b0;
            have_prev        <= 1'b0;
`endif
        end else begin
            meas_valid <= 1'b0;
            if (q == 2'b11) code_error <= 1'b1;
            case (state)
                IDLE: begin
                    if (pulse_start) begin
                        state       <= MEASURE;
                        signal_lost <= 1'b0;
                        cur_pol     <= pol;
                        slots       <= '{default: '0};
                        width_cnt   <= CNT_W'(1);
                        period_cnt  <= CNT_W'(1);
                        pulse_cnt   <= PC_W'(1);
                        idle_cnt    <= '0;
                    end
                end
                MEASURE: begin
                    if (!pulse_start && !pulse_end && idle_cnt == IDLE_LIM) begin
                        state       <= IDLE;
                        signal_lost <= 1'b1;
`ifdef CAPTURE_FULL_PERIOD_EN
                        have_prev   <= 1'b0;
`endif
                    end else begin
                        idle_cnt <= (pulse_start || pulse_end) ? '0 : idle_cnt + 1'b1;
                        if (pulse_start && pol != cur_pol) begin
                            meas_valid    <= 1'b1;
                            meas_polarity <= cur_pol;
                            meas_count    <= (pulse_cnt > PC_W'(3)) ? 2'd3 : pulse_cnt[1:0];
                            for (int k = 0; k < MAX_PULSES; k++)
                                meas_widths[k*CNT_W +: CNT_W] <= slots_upd[k];
                            meas_period   <= period_cnt;
`ifdef CAPTURE_FULL_PERIOD_EN
                            if (have_prev && last_pol != cur_pol)
                                meas_full_period <= {1'b0, last_period} + {1'b0, period_cnt};
                            last_period <= period_cnt;
                            last_pol    <= cur_pol;
                            have_prev   <= 1'b1;
`endif
                            cur_pol    <= pol;
                            slots      <= '{default: '0};
                            width_cnt  <= CNT_W'(1);
                            period_cnt <= CNT_W'(1);
                            pulse_cnt  <= PC_W'(1);
                        end else begin
                            slots      <= slots_upd;
                            period_cnt <= sat_inc(period_cnt);
                            if (pulse_start) begin
                                width_cnt <= CNT_W'(1);
                                if (pulse_cnt != PC_SAT) pulse_cnt <= pulse_cnt + 1'b1;
                            end else if (pulse) begin
                                width_cnt <= sat_inc(width_cnt);
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_three_pulses_pwm_capture.sv
// Bench for three_pulses_pwm_capture: drive-code segments feed a half-cycle reference model whose
// expected measurement records are compared against every meas_valid strobe.
`timescale 1ns/1ps
module tb_three_pulses_pwm_capture;

    localparam int CNT_W       = 16;
    localparam int MAX_PULSES  = 3;
    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT     = 3000;
    localparam int REC_W       = 1 + 2 + 3*CNT_W + CNT_W;

    logic                        clk100MHz = 1'b0;
    logic                        reset     = 1'b1;
    logic [1:0]                  pwm_drive = 2'b00;
    logic                        meas_valid, meas_polarity, code_error, signal_lost, dbg_measuring;
    logic [1:0]                  meas_count;
    logic [MAX_PULSES*CNT_W-1:0] meas_widths;
    logic [CNT_W-1:0]            meas_period;
`ifdef CAPTURE_FULL_PERIOD_EN
    logic [CNT_W:0]              meas_full_period;
`endif

    three_pulses_pwm_capture #(
        .CNT_W(CNT_W), .MAX_PULSES(MAX_PULSES), .SYNC_STAGES(SYNC_STAGES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk100MHz(clk100MHz),
        .reset(reset),
        .pwm_drive(pwm_drive),
        .meas_valid(meas_valid),
        .meas_polarity(meas_polarity),
        .meas_count(meas_count),
        .meas_widths(meas_widths),
        .meas_period(meas_period),
        .code_error(code_error),
        .signal_lost(signal_lost),
`ifdef CAPTURE_FULL_PERIOD_EN
        .meas_full_period(meas_full_period),
`endif
        .dbg_measuring(dbg_measuring)
    );

    // clock / reset
    always #5 clk100MHz = ~clk100MHz;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int seg_cyc = 0;
    int strobe_cyc = 0;
    int strobes = 0;

    always @(posedge clk100MHz) cyc++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // reference model: half-cycles built from pulse start times and widths
    logic [REC_W-1:0] exp_q[$];
    int  full_q[$];
    bit  m_active, m_cur_pol, m_open, m_have_prev;
    int  m_t, m_half_start, m_n, m_last_end, m_open_start, m_open_w, m_open_idx;
    int  m_prev_period, m_exp_full;
    int  m_w[3];
    logic [1:0] m_open_code;

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic m_reset();
        m_active = 0; m_open = 0; m_have_prev = 0; m_exp_full = 0; m_t = 0;
        m_last_end = 0; m_prev_period = 0;
        exp_q.delete();
        full_q.delete();
    endtask

    task automatic m_emit();
        logic [47:0] ws;
        int period;
        ws = '0;
        for (int k = 0; k < 3; k++) ws[k*16 +: 16] = 16'(sat16(m_w[k]));
        period = sat16(m_t - m_half_start);
        exp_q.push_back({m_cur_pol, 2'((m_n > 3) ? 3 : m_n), ws, 16'(period)});
        if (m_have_prev) m_exp_full = m_prev_period + period;
        full_q.push_back(m_exp_full);
        m_prev_period = period;
        m_have_prev = 1;
    endtask

    task automatic m_close();
        if (m_open) begin
            if (m_open_idx <= 3) m_w[m_open_idx-1] = m_open_w;
            m_last_end = m_open_start + m_open_w;
            m_open = 0;
        end
    endtask

    task automatic m_start(input bit p);
        if (m_active && (m_t - m_last_end > TIMEOUT)) begin
            m_active = 0;
            m_have_prev = 0;
        end
        if (m_active && p != m_cur_pol) begin
            m_emit();
            m_active = 0;
        end
        if (!m_active) begin
            m_active = 1; m_cur_pol = p; m_half_start = m_t; m_n = 0;
            m_w = '{0, 0, 0};
        end
        m_n++;
        m_open = 1; m_open_start = m_t; m_open_idx = m_n;
    endtask

    // driver: called at a negedge, holds the code for dur cycles
    task automatic drive(input logic [1:0] code, input int dur);
        pwm_drive = code;
        seg_cyc = cyc;
        if (m_open && code == m_open_code) begin
            m_open_w += dur;
        end else begin
            m_close();
            if (code == 2'b10 || code == 2'b01) begin
                m_start(code[1]);
                m_open_code = code;
                m_open_w = dur;
            end
        end
        m_t += dur;
        repeat (dur) @(negedge clk100MHz);
    endtask

    // scoreboard
    logic [REC_W-1:0] mon_r;
    always @(negedge clk100MHz) begin
        if (!reset && meas_valid) begin
            strobe_cyc = cyc;
            strobes++;
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 64'd1, 64'd0);
            end else begin
                mon_r = exp_q.pop_front();
                check("polarity", 64'(meas_polarity), 64'(mon_r[REC_W-1]));
                check("count", 64'(meas_count), 64'(mon_r[REC_W-2 -: 2]));
                check("widths", 64'(meas_widths), 64'(mon_r[REC_W-4 -: 48]));
                check("period", 64'(meas_period), 64'(mon_r[15:0]));
`ifdef CAPTURE_FULL_PERIOD_EN
                check("full_period", 64'(meas_full_period), 64'(full_q.pop_front()));
`endif
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, 64'(meas_valid), 64'd0);
        check({tag, "_pol"}, 64'(meas_polarity), 64'd0);
        check({tag, "_count"}, 64'(meas_count), 64'd0);
        check({tag, "_widths"}, 64'(meas_widths), 64'd0);
        check({tag, "_period"}, 64'(meas_period), 64'd0);
        check({tag, "_code_error"}, 64'(code_error), 64'd0);
        check({tag, "_signal_lost"}, 64'(signal_lost), 64'd1);
        check({tag, "_measuring"}, 64'(dbg_measuring), 64'd0);
`ifdef CAPTURE_FULL_PERIOD_EN
        check({tag, "_full_period"}, 64'(meas_full_period), 64'd0);
`endif
    endtask

    int s0;
    bit rpol;
    int npulse, gap;

    initial begin
        m_reset();
        repeat (3) @(negedge clk100MHz);
        check_reset_values("reset");
        reset = 1'b0;

        // two positive pulses, then reversal; strobe latency measured from the pin change
        drive(2'b10, 200); drive(2'b00, 800);
        drive(2'b10, 200); drive(2'b00, 800);
        s0 = strobes;
        drive(2'b01, 50);
        check("first_strobe_seen", 64'(strobes - s0), 64'd1);
        check("latency", 64'(strobe_cyc - seg_cyc), 64'(SYNC_STAGES + 2));
        check("signal_lost_running", 64'(signal_lost), 64'd0);

        // negative half-cycle with three pulses 50/100/150
        drive(2'b00, 100); drive(2'b01, 100); drive(2'b00, 100);
        drive(2'b01, 150); drive(2'b00, 100);

        // four positive pulses: only three slots recorded
        for (int i = 0; i < 4; i++) begin
            drive(2'b10, 40); drive(2'b00, 60);
        end
        drive(2'b01, 80);

        // direct 01 -> 10 -> 01 transitions without gaps
        s0 = strobes;
        drive(2'b10, 70);
        drive(2'b01, 60);
        check("direct_strobes", 64'(strobes - s0), 64'd2);
        drive(2'b00, 200);
        drive(2'b10, 30); drive(2'b00, 100);

        // code error then timeout discards the open half-cycle
        drive(2'b11, 5); drive(2'b00, 20);
        check("code_error_set", 64'(code_error), 64'd1);
        check("not_lost_yet", 64'(signal_lost), 64'd0);
        s0 = strobes;
        drive(2'b00, TIMEOUT + 100);
        check("timeout_lost", 64'(signal_lost), 64'd1);
        check("timeout_idle", 64'(dbg_measuring), 64'd0);
        check("timeout_no_strobe", 64'(strobes - s0), 64'd0);
        drive(2'b10, 50);
        check("rearm", 64'(signal_lost), 64'd0);
        drive(2'b00, 100);
        check("code_error_sticky", 64'(code_error), 64'd1);

        // randomized half-cycles
        for (int h = 0; h < 10; h++) begin
            rpol = h[0];
            npulse = $urandom_range(1, 5);
            for (int p = 0; p < npulse; p++) begin
                drive(rpol ? 2'b10 : 2'b01, $urandom_range(1, 200));
                gap = (p == npulse - 1 && $urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 200);
                if (gap > 0) drive(2'b00, gap);
            end
        end
        drive(2'b01, 20); drive(2'b00, 50);

        // steady 20 kHz stream
        for (int h = 0; h < 5; h++) begin
            drive(h[0] ? 2'b01 : 2'b10, 1000);
            drive(2'b00, 1500);
        end
        drive(2'b01, 30);
`ifdef CAPTURE_FULL_PERIOD_EN
        check("full_period_20k", 64'(meas_full_period), 64'd5000);
`endif
        check("pending_before_reset", 64'(exp_q.size()), 64'd0);

        // reset in the middle of a pulse
        reset = 1'b1;
        #1;
        check_reset_values("midreset");
        pwm_drive = 2'b00;
        m_reset();
        repeat (5) @(negedge clk100MHz);
        reset = 1'b0;

        drive(2'b10, 100); drive(2'b00, 100);
        drive(2'b01, 50); drive(2'b00, 50);
        drive(2'b10, 10); drive(2'b00, 30);
        check("pending_end", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
